countdown_seq: RTL
==================

// Module: countdown_seq
// PURPOSE
//  Round-start sequencer for Simon Says on the Basys3 4-digit 7-seg display.
//  On a start request it times READY -> SET -> GO with a 1 s tick, then hands the display to the game datapath.
//  Arbitrates the shared digit/blank bus between its own countdown glyphs and the game.
//  Asserts game_en while the game owns play. Sits between the button debouncer and the 7-seg driver.
// PARAMETERS
//  TICK_DIV     100_000_000  clk cycles per tick (1 s at 100 MHz)
//  CNT_W        27           width of tick divider counter, >= clog2(TICK_DIV)
//  PHASE_TICKS  2            ticks spent in each of READY and SET
//  GO_TICKS     1            ticks spent in GO before PLAY
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-low reset
//  start_req    in   1   1-cycle pulse (debounced): begin a round
//  abort        in   1   level: cancel round, return to IDLE
//  game_digits  in   16  game glyph codes {A,B,C,D}, A = [15:12]
//  game_blank   in   4   game blank mask, 1 = digit off, bit3 = A
//  game_done    in   1   1-cycle pulse: round finished
//  A,B,C,D      out  4   glyph code per digit to 7-seg driver
//  blank        out  4   blank mask to 7-seg driver, 1 = off
//  phase        out  3   current state encoding
//  game_en      out  1   high while in PLAY
//  go_pulse     out  1   1-cycle strobe on entry to PLAY
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, divider=0, phase-tick count=0.
//   Outputs: A..D=0, blank=4'b1111, game_en=0, go_pulse=0, phase=IDLE. Reset wins over all inputs.
//  States (phase code): IDLE=0, READY=1, SET=2, GO=3, PLAY=4.
//  IDLE  --start_req & !abort--> READY. Divider and phase-tick count cleared on the same edge.
//  READY --PHASE_TICKS ticks--> SET;  SET --PHASE_TICKS ticks--> GO.
//  GO    --GO_TICKS ticks--> PLAY.    PLAY --game_done--> IDLE.
//  abort=1 in any state -> IDLE on next edge. abort beats start_req and game_done.
//  start_req outside IDLE is ignored; timing is unaffected.
//  Tick: divider counts 0..TICK_DIV-1 and wraps; tick=1 in the cycle count==TICK_DIV-1.
//   Phase-tick count increments per tick and clears on every state change.
//   Each timed phase therefore lasts exactly N*TICK_DIV cycles.
//  Display outputs are registered from current state: update 1 cycle after the state change.
//   IDLE : A..D=0,                      blank=1111
//   READY: A=0,   B=SEG_R, C=SEG_D, D=SEG_Y,  blank=1000
//   SET  : A=0,   B=SEG_S, C=SEG_E, D=SEG_T,  blank=1000
//   GO   : A=0,   B=0,     C=SEG_G, D=SEG_O,  blank=1100
//   PLAY : {A,B,C,D}=game_digits, blank=game_blank (1-cycle latency)
//  game_en = registered (state==PLAY).
//  go_pulse = 1 for exactly one cycle, aligned with the first cycle game_en=1.
//  Abort or reset during PLAY: game_en drops on the next output update and no go_pulse fires.
//   In-flight game inputs are ignored from that point.
//  No latches: every output is assigned in every state.
// STRUCTURE
//  Shared header simon_defs.vh: state codes and glyph codes.
//   Glyph codes: SEG_R=4'hA, SEG_D=4'h4, SEG_Y=4'hC, SEG_S=4'h5, SEG_E=4'hD,
//   SEG_T=4'h7, SEG_G=4'hB, SEG_O=4'hE. The same codes are used by the 7-seg decoder.
//  Sub-module tick_gen (TICK_DIV, CNT_W): inputs clk, reset, clr; output tick.
//  Top level holds the FSM, phase-tick counter and registered output mux.
// TESTING  (TICK_DIV=4, PHASE_TICKS=2, GO_TICKS=1)
//  1 reset=0 for 2 cycles, other inputs random
//    -> blank=1111, A..D=0, phase=0, game_en=0, go_pulse=0.
//  2 start_req pulse at cycle 0 -> phase=1 from cycle 1; display 0,A,4,C / blank 1000 from cycle 2;
//    phase=2 at cycle 9, =3 at cycle 17, =4 at cycle 21; go_pulse=1 only at cycle 22, game_en=1 from 22.
//  3 in PLAY, game_digits=16'h1234, game_blank=4'b0001 -> A..D=1,2,3,4, blank=0001 one cycle later;
//    game_done pulse -> phase=0 next edge, blank=1111 a cycle later.
//  4 abort=1 for one cycle during SET -> phase=0 next edge, blank=1111, no go_pulse ever;
//    start_req+abort together in IDLE -> stays IDLE.
//  5 extra start_req pulses during READY and GO -> transition cycles identical to scenario 2.
//  6 reset=0 mid-GO (cycle 19) -> all outputs at reset values after that edge;
//    a new start_req then reproduces scenario 2 timing.

Source files
------------

// File: rtl/countdown_seq_pkg.sv
// countdown_seq_pkg: state codes and 7-seg glyph codes shared by the round-start sequencer
package countdown_seq_pkg;
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READY = 3'd1,
      ST_SET   = 3'd2,
      ST_GO    = 3'd3,
      ST_PLAY  = 3'd4
   } state_t;
   localparam logic [3:0] SEG_R = 4'hA;
   localparam logic [3:0] SEG_D = 4'h4;
   localparam logic [3:0] SEG_Y = 4'hC;
   localparam logic [3:0] SEG_S = 4'h5;
   localparam logic [3:0] SEG_E = 4'hD;
   localparam logic [3:0] SEG_T = 4'h7;
   localparam logic [3:0] SEG_G = 4'hB;
   localparam logic [3:0] SEG_O = 4'hE;
   localparam int PT_W = 8;
endpackage

// File: rtl/countdown_seq_tick_gen.sv
// tick_gen: free-running divider that strobes tick once every TICK_DIV cycles
module tick_gen #(
   parameter int TICK_DIV = 100_000_000,
   parameter int CNT_W    = 27
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);
   logic [CNT_W-1:0] cnt;
   assign tick = cnt == CNT_W'(TICK_DIV - 1);
   always_ff @(posedge clk)
      cnt <= (!reset || clr || tick) ? '0 : cnt + CNT_W'(1);
endmodule

// File: rtl/countdown_seq.sv
// countdown_seq: READY/SET/GO round-start sequencer arbitrating the 7-seg bus with the game
module countdown_seq
   import countdown_seq_pkg::*;
#(
   parameter int TICK_DIV    = 100_000_000,
   parameter int CNT_W       = 27,
   parameter int PHASE_TICKS = 2,
   parameter int GO_TICKS    = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_req,
   input  logic        abort,
   input  logic [15:0] game_digits,
   input  logic [3:0]  game_blank,
   input  logic        game_done,
   output logic [3:0]  A,
   output logic [3:0]  B,
   output logic [3:0]  C,
   output logic [3:0]  D,
   output logic [3:0]  blank,
   output logic [2:0]  phase,
   output logic        game_en,
   output logic        go_pulse
);
   state_t state, nxt_state, ost;
   logic [PT_W-1:0] pt_cnt;
   logic tick, start, done_ph, en_d, go_d;
   logic [15:0] disp_d;
   logic [3:0] blank_d;
   assign start = state == ST_IDLE && start_req && !abort;
   assign phase = state;
   tick_gen #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) u_tick (
      .clk   (clk),
      .reset (reset),
      .clr   (start),
      .tick  (tick)
   );
   always_comb begin
      done_ph = tick && pt_cnt == (state == ST_GO ? PT_W'(GO_TICKS - 1) : PT_W'(PHASE_TICKS - 1));
      nxt_state = abort                          ? ST_IDLE  :
                  start                          ? ST_READY :
                  (state == ST_READY && done_ph) ? ST_SET   :
                  (state == ST_SET && done_ph)   ? ST_GO    :
                  (state == ST_GO && done_ph)    ? ST_PLAY  :
                  (state == ST_PLAY && game_done) ? ST_IDLE : state;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= ST_IDLE;
         pt_cnt <= '0;
      end else begin
         state  <= nxt_state;
         pt_cnt <= (nxt_state != state) ? '0 : pt_cnt + PT_W'(tick);
      end
   end
   // an abort already treats the display as IDLE so in-flight game data never reaches the bus
   always_comb begin
      ost     = abort ? ST_IDLE : state;
      disp_d  = ost == ST_READY ? {4'h0, SEG_R, SEG_D, SEG_Y} :
                ost == ST_SET   ? {4'h0, SEG_S, SEG_E, SEG_T} :
                ost == ST_GO    ? {8'h00, SEG_G, SEG_O}       :
                ost == ST_PLAY  ? game_digits                 : 16'h0000;
      blank_d = (ost == ST_READY || ost == ST_SET) ? 4'b1000 :
                ost == ST_GO   ? 4'b1100    :
                ost == ST_PLAY ? game_blank : 4'b1111;
      en_d    = ost == ST_PLAY;
      go_d    = en_d && !game_en;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         {A, B, C, D} <= 16'h0000;
         blank        <= 4'b1111;
         game_en      <= 1'b0;
         go_pulse     <= 1'b0;
      end else begin
         {A, B, C, D} <= disp_d;
         blank        <= blank_d;
         game_en      <= en_d;
         go_pulse     <= go_d;
      end
   end
endmodule
